wb_queue: RTL and testbench

//  Writeback queue that owns the register-file write port. Accepts results from ALU and LSU
//  (valid/ready), buffers them in a DEPTH-entry in-order FIFO, and drains one entry per

---
 rtl/wb_queue.sv | 142 ++++++++++++++
 tb/tb_wb_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback queue that owns the regfile write port.
// LSU and ALU results enter through valid/ready and drain one per cycle.
// rs1/rs2 lookups forward queued-but-unwritten results, youngest match first.
module wb_queue #(
   parameter int WIDTH = 32,
   parameter int ADDR  = 5,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         lsu_valid,
   output logic                         lsu_ready,
   input  logic [ADDR-1:0]              lsu_rd,
   input  logic [WIDTH-1:0]             lsu_wdata,
   input  logic                         alu_valid,
   output logic                         alu_ready,
   input  logic [ADDR-1:0]              alu_rd,
   input  logic [WIDTH-1:0]             alu_wdata,
   output logic                         wr_en,
   output logic [ADDR-1:0]              wr_rd,
   output logic [WIDTH-1:0]             wr_wdata,
   input  logic [ADDR-1:0]              rs1,
   input  logic [ADDR-1:0]              rs2,
   output logic                         fwd1_hit,
   output logic [WIDTH-1:0]             fwd1_data,
   output logic                         fwd2_hit,
   output logic [WIDTH-1:0]             fwd2_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [ADDR-1:0]  rd;
      logic [WIDTH-1:0] data;
   } entry_t;

   entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [PTR_W-1:0]   alu_slot;
   logic [PTR_W-1:0]   fwd_slot;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   free_slots;
   logic               lsu_enq, alu_enq, deq;
   logic [DEPTH-1:0]   slot_vld, slot_hit1, slot_hit2;

   // Admission: free space is judged on start-of-cycle occupancy only, and an
   // rd==0 LSU request is accepted without consuming the slot the ALU may want.
   always_comb begin
      free_slots = CNT_W'(DEPTH) - count_q;
      lsu_ready  = free_slots >= CNT_W'(1);
      alu_ready  = (free_slots >= CNT_W'(2)) ||
                   ((free_slots == CNT_W'(1)) && !(lsu_valid && (lsu_rd != '0)));
      lsu_enq    = lsu_valid && lsu_ready && (lsu_rd != '0);
      alu_enq    = alu_valid && alu_ready && (alu_rd != '0);
      deq        = count_q != '0;
   end

   // Enqueue: LSU lands at tail, ALU behind it so LSU is the older entry.
   always_comb begin
      mem_d    = mem_q;
      alu_slot = tail_q + PTR_W'(lsu_enq);
      if (lsu_enq) begin
         mem_d[tail_q].rd   = lsu_rd;
         mem_d[tail_q].data = lsu_wdata;
      end
      if (alu_enq) begin
         mem_d[alu_slot].rd   = alu_rd;
         mem_d[alu_slot].data = alu_wdata;
      end
      tail_d  = tail_q + PTR_W'(lsu_enq) + PTR_W'(alu_enq);
      head_d  = head_q + PTR_W'(deq);
      count_d = count_q + CNT_W'(lsu_enq) + CNT_W'(alu_enq) - CNT_W'(deq);
   end

   // Pointer and occupancy state; reset discards every queued entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage is qualified by count, so it needs no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Per-slot liveness and tag compare against both lookup ports.
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic [PTR_W-1:0] age;
      assign age          = PTR_W'(g) - head_q;
      assign slot_vld[g]  = CNT_W'(age) < count_q;
      assign slot_hit1[g] = slot_vld[g] && (rs1 != '0) && (mem_q[g].rd == rs1);
      assign slot_hit2[g] = slot_vld[g] && (rs2 != '0) && (mem_q[g].rd == rs2);
   end

   // Forwarding: walk oldest to youngest so the last hit seen is the youngest.
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
      fwd_slot  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_slot = head_q + PTR_W'(i);
         if (slot_hit1[fwd_slot]) begin
            fwd1_hit  = 1'b1;
            fwd1_data = mem_q[fwd_slot].data;
         end
         if (slot_hit2[fwd_slot]) begin
            fwd2_hit  = 1'b1;
            fwd2_data = mem_q[fwd_slot].data;
         end
      end
   end

   // Drain: head entry is presented whenever the queue holds anything.
   always_comb begin
      wr_en    = deq;
      wr_rd    = '0;
      wr_wdata = '0;
      if (deq) begin
         wr_rd    = mem_q[head_q].rd;
         wr_wdata = mem_q[head_q].data;
      end
   end

   assign count = count_q;
   assign empty = count_q == '0;
   assign full  = count_q == CNT_W'(DEPTH);

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: a DEPTH=4 instance carries the main sequence,
// a DEPTH=2 instance sharing the same inputs is used where full is reachable.
module tb_wb_queue;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        lsu_valid = 1'b0, alu_valid = 1'b0;
   logic [4:0]  lsu_rd = '0, alu_rd = '0, rs1 = '0, rs2 = '0;
   logic [31:0] lsu_wdata = '0, alu_wdata = '0;

   logic        lsu_ready, alu_ready, wr_en, fwd1_hit, fwd2_hit, empty, full;
   logic [4:0]  wr_rd;
   logic [31:0] wr_wdata, fwd1_data, fwd2_data;
   logic [2:0]  count;

   logic        lsu_ready2, alu_ready2, wr_en2, fwd1_hit2, fwd2_hit2, empty2, full2;
   logic [4:0]  wr_rd2;
   logic [31:0] wr_wdata2, fwd1_data2, fwd2_data2;
   logic [1:0]  count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_queue #(.WIDTH(32), .ADDR(5), .DEPTH(4)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
      .wr_en(wr_en), .wr_rd(wr_rd), .wr_wdata(wr_wdata),
      .rs1(rs1), .rs2(rs2),
      .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
      .count(count), .empty(empty), .full(full)
   );

   wb_queue #(.WIDTH(32), .ADDR(5), .DEPTH(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready2), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
      .alu_valid(alu_valid), .alu_ready(alu_ready2), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
      .wr_en(wr_en2), .wr_rd(wr_rd2), .wr_wdata(wr_wdata2),
      .rs1(rs1), .rs2(rs2),
      .fwd1_hit(fwd1_hit2), .fwd1_data(fwd1_data2), .fwd2_hit(fwd2_hit2), .fwd2_data(fwd2_data2),
      .count(count2), .empty(empty2), .full(full2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      lsu_valid = v; lsu_rd = rd; lsu_wdata = d;
   endtask

   task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      alu_valid = v; alu_rd = rd; alu_wdata = d;
   endtask

   task automatic clr_in();
      set_lsu(1'b0, 5'd0, 32'd0);
      set_alu(1'b0, 5'd0, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      // reset state
      rs1 = 5'd5;
      #2;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_lsu_ready", lsu_ready, 1);
      chk("rst_alu_ready", alu_ready, 1);
      chk("rst_fwd1_hit", fwd1_hit, 0);
      chk("rst_fwd1_data", fwd1_data, 0);
      chk("rst_wr_rd", wr_rd, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // 1: single ALU write, presented for exactly one cycle
      set_alu(1'b1, 5'd5, 32'hDEAD);
      #1;
      chk("t1_alu_ready", alu_ready, 1);
      chk("t1_no_inflight_fwd", fwd1_hit, 0);
      tick(); clr_in();
      chk("t1_wr_en", wr_en, 1);
      chk("t1_wr_rd", wr_rd, 5);
      chk("t1_wr_wdata", wr_wdata, 32'hDEAD);
      chk("t1_fwd1_hit", fwd1_hit, 1);
      chk("t1_fwd1_data", fwd1_data, 32'hDEAD);
      tick();
      chk("t1_wr_en_drop", wr_en, 0);
      chk("t1_empty", empty, 1);
      chk("t1_wr_wdata_zero", wr_wdata, 0);

      // 2: same-cycle LSU/ALU to x3, LSU older, youngest forwarded
      rs1 = 5'd3;
      set_lsu(1'b1, 5'd3, 32'd1);
      set_alu(1'b1, 5'd3, 32'd2);
      #1;
      chk("t2_lsu_ready", lsu_ready, 1);
      chk("t2_alu_ready", alu_ready, 1);
      tick(); clr_in();
      chk("t2_count", count, 2);
      chk("t2_wr0", wr_wdata, 1);
      chk("t2_fwd_hit0", fwd1_hit, 1);
      chk("t2_fwd_data0", fwd1_data, 2);
      tick();
      chk("t2_wr1", wr_wdata, 2);
      chk("t2_wr_rd1", wr_rd, 3);
      chk("t2_fwd_data1", fwd1_data, 2);
      tick();
      chk("t2_empty", empty, 1);
      chk("t2_fwd_gone", fwd1_hit, 0);

      // 3/4: dual enqueue, DEPTH=2 fills, DEPTH=4 saturates at 3 with drain
      do_reset();
      rs1 = 5'd0;
      set_lsu(1'b1, 5'd1, 32'h11);
      set_alu(1'b1, 5'd2, 32'h22);
      tick();
      set_lsu(1'b1, 5'd3, 32'h33);
      set_alu(1'b1, 5'd4, 32'h44);
      #1;
      chk("t3_count", count, 2);
      chk("t3_wr_rd_first", wr_rd, 1);
      chk("t3_d2_full", full2, 1);
      chk("t3_d2_count", count2, 2);
      chk("t3_d2_lsu_ready", lsu_ready2, 0);
      chk("t3_d2_alu_ready", alu_ready2, 0);
      chk("t3_alu_ready", alu_ready, 1);
      tick();
      chk("t3_count3", count, 3);
      chk("t3_full", full, 0);
      chk("t3_wr_rd2", wr_rd, 2);
      chk("t3_d2_count1", count2, 1);
      chk("t3_d2_notfull", full2, 0);
      chk("t3_d2_wr_rd", wr_rd2, 2);
      // count == DEPTH-1 with both producers targeting non-zero rd
      rs2 = 5'd6;
      set_lsu(1'b1, 5'd6, 32'h66);
      set_alu(1'b1, 5'd7, 32'h77);
      #1;
      chk("t4_lsu_ready", lsu_ready, 1);
      chk("t4_alu_blocked", alu_ready, 0);
      tick();
      chk("t4_count", count, 3);
      chk("t4_wr_rd3", wr_rd, 3);
      chk("t4_fwd2_hit", fwd2_hit, 1);
      chk("t4_fwd2_data", fwd2_data, 32'h66);
      // LSU rd=0 takes no slot, so the ALU gets the last one
      set_lsu(1'b1, 5'd0, 32'h99);
      #1;
      chk("t4_rd0_lsu_ready", lsu_ready, 1);
      chk("t4_alu_accept", alu_ready, 1);
      tick(); clr_in();
      chk("t4_count_after", count, 3);
      chk("t4_wr_rd4", wr_rd, 4);
      chk("t4_wr_data4", wr_wdata, 32'h44);
      tick();
      chk("t4_wr_rd6", wr_rd, 6);
      chk("t4_wr_data6", wr_wdata, 32'h66);
      tick();
      chk("t4_wr_rd7", wr_rd, 7);
      chk("t4_wr_data7", wr_wdata, 32'h77);
      tick();
      chk("t4_empty", empty, 1);
      chk("t4_wr_en_off", wr_en, 0);
      rs2 = 5'd0;

      // 5: ALU rd=0 handshakes without enqueue
      rs1 = 5'd0;
      set_alu(1'b1, 5'd0, 32'h55);
      #1;
      chk("t5_alu_ready", alu_ready, 1);
      tick(); clr_in();
      chk("t5_count", count, 0);
      chk("t5_wr_en", wr_en, 0);
      chk("t5_fwd1_hit", fwd1_hit, 0);
      chk("t5_fwd1_data", fwd1_data, 0);

      // 6: async reset with 3 queued, then 10 serial writes across wrap
      set_lsu(1'b1, 5'd8, 32'h80);
      set_alu(1'b1, 5'd9, 32'h90);
      tick();
      set_lsu(1'b1, 5'd10, 32'hA0);
      set_alu(1'b1, 5'd11, 32'hB0);
      tick(); clr_in();
      chk("t6_count_pre", count, 3);
      rs1 = 5'd11;
      #1;
      chk("t6_fwd_pre", fwd1_hit, 1);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_wr_en", wr_en, 0);
      chk("t6_rst_count", count, 0);
      chk("t6_rst_empty", empty, 1);
      chk("t6_rst_fwd", fwd1_hit, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      for (int i = 1; i <= 10; i++) begin
         set_alu(1'b1, 5'(i), 32'h100 + 32'(i));
         tick();
         chk("t6_serial_rd", wr_rd, 64'(i));
         chk("t6_serial_data", wr_wdata, 64'h100 + 64'(i));
         chk("t6_serial_count", count, 1);
      end
      clr_in();
      tick();
      chk("t6_final_empty", empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
